// File: rtl/cc_delay_release.sv
// Hold-and-release stage: captures a word on load, counts T cycles down, then presents it until acked.
// Optional one-entry skid buffer (data + T) enabled by defining CC_DELAYRELEASE_SKID_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | empty, ready for a load
// ST_COUNT | item captured, counter running down to terminal count 0
// ST_HOLD  | item released on Data_OutBus, Valid_Out high until ack
module cc_delay_release #(
  parameter int DATAWIDTH_BUS  = 8,
  parameter int COUNTWIDTH_BUS = 16
) (
  input  logic                      CC_DELAYRELEASE_CLOCK_50,
  input  logic                      CC_DELAYRELEASE_RESET_InHigh,
  input  logic [DATAWIDTH_BUS-1:0]  CC_DELAYRELEASE_Data_inBus,
  input  logic [COUNTWIDTH_BUS-1:0] CC_DELAYRELEASE_Ticks_inBus,
  input  logic                      CC_DELAYRELEASE_Load_In,
  output logic                      CC_DELAYRELEASE_Ready_Out,
  output logic [DATAWIDTH_BUS-1:0]  CC_DELAYRELEASE_Data_OutBus,
  output logic                      CC_DELAYRELEASE_Valid_Out,
  input  logic                      CC_DELAYRELEASE_Ack_In
);

  typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_HOLD} state_t;

  localparam logic [COUNTWIDTH_BUS-1:0] CNT_ZERO = '0;
  localparam logic [COUNTWIDTH_BUS-1:0] CNT_ONE  = COUNTWIDTH_BUS'(1);

  state_t                    state_q, state_d;
  logic [COUNTWIDTH_BUS-1:0] cnt_q, cnt_d;
  logic [DATAWIDTH_BUS-1:0]  data_q, data_d;
  logic [DATAWIDTH_BUS-1:0]  dout_q, dout_d;
  logic                      ready;
  logic                      load_ok;
  logic                      ack_ok;

`ifdef CC_DELAYRELEASE_SKID_EN
  logic                      skid_full_q, skid_full_d;
  logic [DATAWIDTH_BUS-1:0]  skid_data_q, skid_data_d;
  logic [COUNTWIDTH_BUS-1:0] skid_t_q, skid_t_d;

  assign ready = !skid_full_q;
`else
  assign ready = (state_q == ST_IDLE);
`endif

  assign load_ok = CC_DELAYRELEASE_Load_In && ready;
  assign ack_ok  = CC_DELAYRELEASE_Ack_In && (state_q == ST_HOLD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    dout_d  = dout_q;
`ifdef CC_DELAYRELEASE_SKID_EN
    skid_full_d = skid_full_q;
    skid_data_d = skid_data_q;
    skid_t_d    = skid_t_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (load_ok) begin
          data_d  = CC_DELAYRELEASE_Data_inBus;
          cnt_d   = CC_DELAYRELEASE_Ticks_inBus;
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (cnt_q == CNT_ZERO) begin
          dout_d  = data_q;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
`ifdef CC_DELAYRELEASE_SKID_EN
        if (load_ok) begin
          skid_full_d = 1'b1;
          skid_data_d = CC_DELAYRELEASE_Data_inBus;
          skid_t_d    = CC_DELAYRELEASE_Ticks_inBus;
        end
`endif
      end
      ST_HOLD: begin
`ifdef CC_DELAYRELEASE_SKID_EN
        if (ack_ok) begin
          if (skid_full_q) begin
            data_d      = skid_data_q;
            cnt_d       = skid_t_q;
            skid_full_d = 1'b0;
            state_d     = ST_COUNT;
          end else if (load_ok) begin
            // Ack and load on the same edge: new item bypasses the skid.
            data_d  = CC_DELAYRELEASE_Data_inBus;
            cnt_d   = CC_DELAYRELEASE_Ticks_inBus;
            state_d = ST_COUNT;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (load_ok) begin
          skid_full_d = 1'b1;
          skid_data_d = CC_DELAYRELEASE_Data_inBus;
          skid_t_d    = CC_DELAYRELEASE_Ticks_inBus;
        end
`else
        if (ack_ok) begin
          state_d = ST_IDLE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CC_DELAYRELEASE_CLOCK_50) begin
    if (CC_DELAYRELEASE_RESET_InHigh) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      dout_q  <= '0;
`ifdef CC_DELAYRELEASE_SKID_EN
      skid_full_q <= 1'b0;
      skid_data_q <= '0;
      skid_t_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      dout_q  <= dout_d;
`ifdef CC_DELAYRELEASE_SKID_EN
      skid_full_q <= skid_full_d;
      skid_data_q <= skid_data_d;
      skid_t_q    <= skid_t_d;
`endif
    end
  end

  assign CC_DELAYRELEASE_Ready_Out   = ready;
  assign CC_DELAYRELEASE_Valid_Out   = (state_q == ST_HOLD);
  assign CC_DELAYRELEASE_Data_OutBus = dout_q;

endmodule
